// File: rtl/accum_cpu_pkg.sv
// accum_cpu_pkg: opcode encodings and FSM states shared by the accumulator CPU
package accum_cpu_pkg;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_SRL  = 3'd2;
  localparam logic [2:0] OP_LT   = 3'd3;
  localparam logic [2:0] OP_BZ   = 3'd4;
  localparam logic [2:0] OP_CP2W = 3'd5;
  localparam logic [2:0] OP_CPFW = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;
  typedef enum logic [2:0] {FETCH, PTR, OPER, STORE, HALT} state_t;
endpackage

// File: rtl/accum_cpu_hs_if.sv
// accum_cpu_hs_if: req/ack single-port memory bus between the CPU (master) and RAM (slave)
//   mem_req/mem_we/mem_addr/mem_wdata driven by master, held until mem_req&mem_ack
//   mem_rdata/mem_ack driven by slave; rdata valid in the ack cycle of a read
interface accum_cpu_hs_if #(parameter int DW = 16, parameter int AW = 10);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/accum_alu.sv
// accum_alu: combinational next-W for the accumulator CPU
//   w, num : accumulator and operand word; op : 3-bit opcode; w_next : result mod 2^DW
module accum_alu import accum_cpu_pkg::*; #(parameter int DW = 16) (
  input  logic [DW-1:0] w,
  input  logic [DW-1:0] num,
  input  logic [2:0]    op,
  output logic [DW-1:0] w_next
);
  always_comb begin
    w_next = w;
    case (op)
      OP_ADD:  w_next = w + num;
      OP_NAND: w_next = ~(w & num);
      // shift amounts beyond DW turn into a left shift by the excess
      OP_SRL:  w_next = num <= DW'(DW) ? w >> num : w << (num - DW'(DW));
      OP_LT:   w_next = DW'(w < num);
      OP_CP2W: w_next = num;
      OP_MUL:  w_next = w * num;
      default: w_next = w;
    endcase
  end
endmodule

// File: rtl/accum_cpu_hs.sv
// accum_cpu_hs: multi-cycle accumulator CPU with req/ack memory handshake
//   clk, rst : clock, asynchronous active-high reset
//   mem      : master side of the memory bus (program and data share one RAM)
//   pc       : program counter; w_acc : accumulator W; halted : sticky BZ-to-self stop
module accum_cpu_hs import accum_cpu_pkg::*; #(
  parameter int DW       = 16,
  parameter int AW       = 10,
  parameter int IND_ADDR = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  accum_cpu_hs_if.master       mem,
  output logic [AW-1:0]        pc,
  output logic [DW-1:0]        w_acc,
  output logic                 halted
);
  state_t        st;
  logic [2:0]    opc;
  logic [AW-1:0] eff;
  logic [DW-1:0] w;
  logic [DW-1:0] w_nxt;
  logic          done;
  logic [2:0]    r_op;
  logic [AW-1:0] r_lo;
  assign done = mem.mem_req & mem.mem_ack;
  assign r_op = mem.mem_rdata[DW-1:DW-3];
  assign r_lo = mem.mem_rdata[AW-1:0];
  assign w_acc = w;
  // request is a decode of the state so each state issues its access in its first cycle;
  // gating with rst drops an outstanding request the moment reset asserts
  assign mem.mem_req   = ~rst & (st != HALT);
  assign mem.mem_we    = st == STORE;
  assign mem.mem_addr  = st == FETCH ? pc : st == PTR ? AW'(IND_ADDR) : eff;
  assign mem.mem_wdata = st == STORE ? w : '0;
  accum_alu #(.DW(DW)) u_alu (.w(w), .num(mem.mem_rdata), .op(opc), .w_next(w_nxt));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st     <= FETCH;
      pc     <= '0;
      w      <= '0;
      opc    <= '0;
      eff    <= '0;
      halted <= 1'b0;
    end else if (done) begin
      case (st)
        FETCH: begin
          opc <= r_op;
          eff <= r_lo;
          st  <= mem.mem_rdata[DW-4:0] == '0 ? PTR : r_op == OP_CPFW ? STORE : OPER;
        end
        PTR: begin
          eff <= r_lo;
          st  <= opc == OP_CPFW ? STORE : OPER;
        end
        OPER:
          if (opc == OP_BZ && w == '0 && r_lo == pc) begin
            st     <= HALT;
            halted <= 1'b1;
          end else begin
            st <= FETCH;
            w  <= w_nxt;
            pc <= opc == OP_BZ && w == '0 ? r_lo : pc + AW'(1);
          end
        STORE: begin
          st <= FETCH;
          pc <= pc + AW'(1);
        end
        default: st <= st;
      endcase
    end
endmodule
